async_fifo_wr_arbiter: RTL

- Shares the single write port of the async FIFO between NUM_REQ requesters in the write clock domain.
- Grants use round-robin arbitration with burst locking: a requester keeps the port for up to MAX_BURST beats, then must re-arbitrate.
- Honours wfull from the FIFO so the FIFO can never be overflowed.
- Drives the FIFO's winc/wdata directly and exposes grant status for the bench monitor.

---
 rtl/async_fifo_wr_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/async_fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter sharing one async FIFO write port
// between NUM_REQ requesters in the write clock domain.
module async_fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                              wclk,
    input  logic                              wrst,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_data,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic                              wfull,
    output logic                              winc,
    output logic [DATA_WIDTH-1:0]             wdata,
    output logic                              gnt_valid,
    output logic [ID_W-1:0]                   gnt_id,
    output logic [$clog2(MAX_BURST+1)-1:0]    beat_cnt,
    output logic [15:0]                       wr_total
);

    localparam int BC_W = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          r_state;
    logic            r_gnt_valid;
    logic [ID_W-1:0] r_gnt_id;
    logic [ID_W-1:0] r_last_owner;
    logic [BC_W-1:0] r_beat_cnt;
    logic [15:0]     r_wr_total;

    logic            w_own_valid;
    logic            w_beat;
    logic            w_last_beat;
    logic            w_release;
    logic            w_win_found;
    logic [ID_W-1:0] w_base;
    logic [ID_W-1:0] w_win_id;

    assign w_own_valid = req_valid[r_gnt_id];
    assign winc        = !wrst && r_gnt_valid && w_own_valid && !wfull;
    assign w_beat      = winc;
    assign w_last_beat = (r_beat_cnt == BC_W'(MAX_BURST - 1));
    assign w_release   = r_gnt_valid &&
                         ((w_beat && w_last_beat) || !w_own_valid);

    assign wdata = r_gnt_valid ?
                   req_data[int'(r_gnt_id)*DATA_WIDTH +: DATA_WIDTH] :
                   '0;

    assign gnt_valid = r_gnt_valid;
    assign gnt_id    = r_gnt_id;
    assign beat_cnt  = r_beat_cnt;
    assign wr_total  = r_wr_total;

    always_comb begin
        req_ready = '0;
        if (!wrst && r_gnt_valid && !wfull) begin
            req_ready[r_gnt_id] = 1'b1;
        end
    end

    // On release the current owner becomes last_owner, so searching from
    // gnt_id+1 gives it the lowest priority in the same-edge re-arbitration.
    always_comb begin
        w_base      = (r_state == GRANT) ? r_gnt_id : r_last_owner;
        w_win_found = 1'b0;
        w_win_id    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!w_win_found &&
                req_valid[(int'(w_base) + i) % NUM_REQ]) begin
                w_win_found = 1'b1;
                w_win_id    = ID_W'((int'(w_base) + i) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            r_state      <= IDLE;
            r_gnt_valid  <= 1'b0;
            r_gnt_id     <= '0;
            r_beat_cnt   <= '0;
            r_wr_total   <= '0;
            r_last_owner <= ID_W'(NUM_REQ - 1);
        end else begin
            if (w_beat) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
                r_wr_total <= r_wr_total + 16'd1;
            end
            case (r_state)
                IDLE: begin
                    if (w_win_found) begin
                        r_state     <= GRANT;
                        r_gnt_valid <= 1'b1;
                        r_gnt_id    <= w_win_id;
                        r_beat_cnt  <= '0;
                    end
                end
                GRANT: begin
                    if (w_release) begin
                        r_last_owner <= r_gnt_id;
                        r_beat_cnt   <= '0;
                        if (w_win_found) begin
                            r_gnt_id <= w_win_id;
                        end else begin
                            r_state     <= IDLE;
                            r_gnt_valid <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

endmodule
